// File: rtl/fpu_pkg.sv
// Shared definitions for the bf16 multiplier and its writeback stage.
// Provides the default format widths, the bit positions of the class flags
// and the exception flags, and helpers that build canonical special values.
package fpu_pkg;

  localparam int unsigned NEXP        = 8;
  localparam int unsigned NSIG        = 7;
  localparam int unsigned NTYPES      = 6;
  localparam int unsigned NEXCEPTIONS = 5;

  // Class flag bit positions
  localparam int unsigned FLAG_QNAN      = 0;
  localparam int unsigned FLAG_SNAN      = 1;
  localparam int unsigned FLAG_INFINITY  = 2;
  localparam int unsigned FLAG_ZERO      = 3;
  localparam int unsigned FLAG_SUBNORMAL = 4;
  localparam int unsigned FLAG_NORMAL    = 5;

  // Exception flag bit positions
  localparam int unsigned EXC_INVALID   = 0;
  localparam int unsigned EXC_DIVBYZERO = 1;
  localparam int unsigned EXC_OVERFLOW  = 2;
  localparam int unsigned EXC_UNDERFLOW = 3;
  localparam int unsigned EXC_INEXACT   = 4;

  // Quiet NaN: all-ones exponent, MSB of significand set, rest zero.
  function automatic logic [NEXP+NSIG:0] canon_qnan(input logic sign);
    return {sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
  endfunction

  // Infinity: all-ones exponent, zero significand.
  function automatic logic [NEXP+NSIG:0] canon_inf(input logic sign);
    return {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with valid/ready handshakes and an occupancy count.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   in_valid_i/in_ready_o      write handshake, in_data_i payload
//   out_valid_o/out_ready_i    read handshake, out_data_o head payload
//   count_o                    current occupancy (0..DEPTH)
// in_ready_o/out_valid_o come from registered count only; storage is not reset.
module fpu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             accept, pop;

  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != '0);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/fpu_result_writeback.sv
// Writeback stage behind the combinational bf16 multiplier.
// Buffers product/class/exception words in a small FIFO, turning any NaN
// into the canonical quiet NaN (and flagging INVALID) as it is written,
// accumulates sticky exception status and pulses trap for enabled exceptions.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_valid/in_ready, in_p/in_flags/in_exc      producer side
//   out_valid/out_ready, out_p/out_flags/out_exc consumer side
//   count                             FIFO occupancy
//   sticky_exc, sticky_clr            accumulated exceptions and their clear
//   exc_en, trap                      trap enable mask and one-cycle trap pulse
module fpu_result_writeback
  import fpu_pkg::*;
#(
  parameter int unsigned NEXP        = fpu_pkg::NEXP,
  parameter int unsigned NSIG        = fpu_pkg::NSIG,
  parameter int unsigned NTYPES      = fpu_pkg::NTYPES,
  parameter int unsigned NEXCEPTIONS = fpu_pkg::NEXCEPTIONS,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NEXP+NSIG:0]       in_p,
  input  logic [NTYPES-1:0]        in_flags,
  input  logic [NEXCEPTIONS-1:0]   in_exc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NEXP+NSIG:0]       out_p,
  output logic [NTYPES-1:0]        out_flags,
  output logic [NEXCEPTIONS-1:0]   out_exc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [NEXCEPTIONS-1:0]   sticky_exc,
  input  logic                     sticky_clr,
  input  logic [NEXCEPTIONS-1:0]   exc_en,
  output logic                     trap
);

  localparam int unsigned PW = NEXP + NSIG + 1;
  localparam int unsigned W  = PW + NTYPES + NEXCEPTIONS;

  logic                   is_nan;
  logic [PW-1:0]          st_p;
  logic [NTYPES-1:0]      st_flags;
  logic [NEXCEPTIONS-1:0] st_exc;
  logic                   accept;
  logic [W-1:0]           head;

  logic [NEXCEPTIONS-1:0] sticky_q, sticky_d;
  logic                   trap_q, trap_d;

  assign is_nan = in_flags[FLAG_SNAN] | in_flags[FLAG_QNAN];

  always_comb begin
    st_p     = in_p;
    st_flags = in_flags;
    st_exc   = in_exc;
    if (is_nan) begin
      st_p                = {in_p[PW-1], {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      st_flags[FLAG_QNAN] = 1'b1;
      st_flags[FLAG_SNAN] = 1'b0;
      st_exc[EXC_INVALID] = 1'b1;
    end
  end

  fpu_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({st_p, st_flags, st_exc}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head),
    .count_o     (count)
  );

  assign {out_p, out_flags, out_exc} = head;

  assign accept = in_valid & in_ready;

  // A clear coinciding with an accept keeps the new word's exceptions.
  always_comb begin
    sticky_d = sticky_q;
    if (accept && sticky_clr) sticky_d = st_exc;
    else if (accept)          sticky_d = sticky_q | st_exc;
    else if (sticky_clr)      sticky_d = '0;
    trap_d = accept & (|(st_exc & exc_en));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      trap_q   <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      trap_q   <= trap_d;
    end
  end

  assign sticky_exc = sticky_q;
  assign trap       = trap_q;

endmodule
